// File: rtl/dpu_reg_bridge.sv
// CPU-side register bridge for the display unit. Single-word bus reads and writes
// land in shadow registers. The shadow is copied to the DPU inputs on the vsync
// falling edge, so a frame never mixes old and new state. In immediate mode the
// copy happens on every shadow write instead.
module dpu_reg_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'hFF000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  input  logic        vsync,
  output logic [2:0]  gameState,
  output logic [1:0]  p1State,
  output logic [1:0]  p2State,
  output logic [3:0]  p1health,
  output logic [3:0]  p2health,
  output logic [10:0] x1,
  output logic [10:0] y1,
  output logic [10:0] x2,
  output logic [10:0] y2,
  output logic        p1Left,
  output logic        p2Left,
  output logic        pending,
  output logic [15:0] frame_cnt
);

  typedef struct packed {
    logic [2:0]  game;
    logic [1:0]  p1_state;
    logic        p1_left;
    logic [3:0]  p1_health;
    logic [1:0]  p2_state;
    logic        p2_left;
    logic [3:0]  p2_health;
    logic [10:0] x1;
    logic [10:0] y1;
    logic [10:0] x2;
    logic [10:0] y2;
  } fields_t;

  fields_t     shadow_q, shadow_d;
  fields_t     commit_q, commit_d;
  logic        mode_q, mode_d;
  logic        pending_q, pending_d;
  logic [15:0] frame_q, frame_d;
  logic        vsync_q;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;

  logic        in_win, wr_req, rd_req;
  logic [5:0]  word_off;
  logic        shadow_wr, force_commit, vsync_fall, commit_shadow;
  logic [31:0] rd_word;

  logic        unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:27], wdata[15:11]};

  function automatic logic [3:0] clamp_health(input logic [3:0] h);
    return (h > 4'd9) ? 4'd9 : h;
  endfunction

  // The DPU draws at 500 - y, so larger values would wrap on screen.
  function automatic logic [10:0] clamp_y(input logic [10:0] y);
    return (y > 11'd500) ? 11'd500 : y;
  endfunction

  assign in_win     = (addr[31:8] == BASE_ADDR[31:8]);
  assign wr_req     = wr_en & in_win;
  assign rd_req     = rd_en & in_win;
  assign word_off   = addr[7:2];
  assign vsync_fall = vsync_q & ~vsync;

  // Decode the write into the shadow, mode and force-commit strobe.
  always_comb begin
    shadow_d     = shadow_q;
    mode_d       = mode_q;
    shadow_wr    = 1'b0;
    force_commit = 1'b0;
    if (wr_req) begin
      case (word_off)
        6'h00: begin
          shadow_d.game = wdata[2:0];
          shadow_wr     = 1'b1;
        end
        6'h01: begin
          shadow_d.p1_state  = wdata[1:0];
          shadow_d.p1_left   = wdata[2];
          shadow_d.p1_health = clamp_health(wdata[7:4]);
          shadow_wr          = 1'b1;
        end
        6'h02: begin
          shadow_d.p2_state  = wdata[1:0];
          shadow_d.p2_left   = wdata[2];
          shadow_d.p2_health = clamp_health(wdata[7:4]);
          shadow_wr          = 1'b1;
        end
        6'h03: begin
          shadow_d.x1 = wdata[10:0];
          shadow_d.y1 = clamp_y(wdata[26:16]);
          shadow_wr   = 1'b1;
        end
        6'h04: begin
          shadow_d.x2 = wdata[10:0];
          shadow_d.y2 = clamp_y(wdata[26:16]);
          shadow_wr   = 1'b1;
        end
        6'h05: begin
          mode_d       = wdata[0];
          force_commit = wdata[1];
        end
        default: ;
      endcase
    end
  end

  // Commit and pending control. A vsync commit takes the pre-write shadow, so a
  // coincident write is deferred to the next frame and leaves pending set.
  always_comb begin
    commit_d      = commit_q;
    pending_d     = pending_q;
    frame_d       = vsync_fall ? frame_q + 16'd1 : frame_q;
    commit_shadow = force_commit | (vsync_fall & mode_q);
    if (commit_shadow) begin
      commit_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (shadow_wr && !mode_q) begin
      commit_d  = shadow_d;
      pending_d = 1'b0;
    end
    if (shadow_wr && mode_q) begin
      pending_d = 1'b1;
    end
  end

  // Read mux over the shadow; unused bits and unmapped offsets return 0.
  always_comb begin
    rd_word = '0;
    case (word_off)
      6'h00: rd_word = {29'b0, shadow_q.game};
      6'h01: rd_word = {24'b0, shadow_q.p1_health, 1'b0, shadow_q.p1_left, shadow_q.p1_state};
      6'h02: rd_word = {24'b0, shadow_q.p2_health, 1'b0, shadow_q.p2_left, shadow_q.p2_state};
      6'h03: rd_word = {5'b0, shadow_q.y1, 5'b0, shadow_q.x1};
      6'h04: rd_word = {5'b0, shadow_q.y2, 5'b0, shadow_q.x2};
      6'h05: rd_word = {23'b0, pending_q, 7'b0, mode_q};
      6'h06: rd_word = {16'b0, frame_q};
      default: rd_word = '0;
    endcase
    ack_d   = wr_req | rd_req;
    // A simultaneous write wins and the read returns 0.
    rdata_d = (rd_req && !wr_en) ? rd_word : 32'b0;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q  <= '0;
      commit_q  <= '0;
      mode_q    <= 1'b1;
      pending_q <= 1'b0;
      frame_q   <= '0;
      vsync_q   <= 1'b1;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      shadow_q  <= shadow_d;
      commit_q  <= commit_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      frame_q   <= frame_d;
      vsync_q   <= vsync;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rdata     = rdata_q;
  assign ack       = ack_q;
  assign pending   = pending_q;
  assign frame_cnt = frame_q;
  assign gameState = commit_q.game;
  assign p1State   = commit_q.p1_state;
  assign p2State   = commit_q.p2_state;
  assign p1health  = commit_q.p1_health;
  assign p2health  = commit_q.p2_health;
  assign p1Left    = commit_q.p1_left;
  assign p2Left    = commit_q.p2_left;
  assign x1        = commit_q.x1;
  assign y1        = commit_q.y1;
  assign x2        = commit_q.x2;
  assign y2        = commit_q.y2;

endmodule

// File: tb/tb_dpu_reg_bridge.sv
// Self-checking bench for dpu_reg_bridge. Read expectations go through a queue
// and are popped when the acknowledge appears.
`timescale 1ns/1ps
module tb_dpu_reg_bridge;

  logic        clk = 1'b0;
  logic        rst, wr_en, rd_en, vsync;
  logic [31:0] addr, wdata, rdata;
  logic        ack, pending, p1Left, p2Left;
  logic [2:0]  gameState;
  logic [1:0]  p1State, p2State;
  logic [3:0]  p1health, p2health;
  logic [10:0] x1, y1, x2, y2;
  logic [15:0] frame_cnt;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_v;

  localparam logic [31:0] B = 32'hFF000000;

  dpu_reg_bridge dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .vsync(vsync), .gameState(gameState), .p1State(p1State),
    .p2State(p2State), .p1health(p1health), .p2health(p2health), .x1(x1), .y1(y1),
    .x2(x2), .y2(y2), .p1Left(p1Left), .p2Left(p2Left), .pending(pending),
    .frame_cnt(frame_cnt)
  );

  always #50 clk = ~clk;

  // Drive one request cycle and return at the next falling edge (response visible).
  task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    wr_en = w; rd_en = r; addr = a; wdata = d;
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic test_reset();
    idle(); vsync = 1'b1; rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({gameState, p1State, p2State, p1health, p2health, x1, y1, x2, y2, p1Left, p2Left,
         pending, frame_cnt, ack, rdata} !== '0) begin
      failures++; $display("FAIL reset_outputs got nonzero output, required all 0");
    end
    sb_q.push_back(32'h1);
    drive(1'b0, 1'b1, B + 32'h14, '0);
    exp_v = sb_q.pop_front();
    checks++;
    if (ack !== 1'b1 || rdata !== exp_v) begin
      failures++; $display("FAIL reset_ctrl ack=%0b rdata=%h required %h", ack, rdata, exp_v);
    end
    sb_q.push_back(32'h0);
    drive(1'b0, 1'b1, B + 32'h18, '0);
    exp_v = sb_q.pop_front();
    checks++;
    if (ack !== 1'b1 || rdata !== exp_v) begin
      failures++; $display("FAIL reset_status ack=%0b rdata=%h required %h", ack, rdata, exp_v);
    end
    idle(); @(negedge clk);
  endtask

  task automatic test_vsync_commit();
    drive(1'b1, 1'b0, B + 32'h0C, 32'h00C80064);
    checks++;
    if (ack !== 1'b1 || x1 !== 11'd0 || y1 !== 11'd0 || pending !== 1'b1) begin
      failures++;
      $display("FAIL vsc_write ack=%0b x1=%0d y1=%0d pend=%0b required 1 0 0 1", ack, x1, y1, pending);
    end
    sb_q.push_back(32'h00C80064);
    drive(1'b0, 1'b1, B + 32'h0C, '0);
    exp_v = sb_q.pop_front();
    checks++;
    if (ack !== 1'b1 || rdata !== exp_v) begin
      failures++; $display("FAIL vsc_readback rdata=%h required %h", rdata, exp_v);
    end
    idle(); vsync = 1'b0;
    @(negedge clk);
    checks++;
    if (x1 !== 11'd100 || y1 !== 11'd200 || pending !== 1'b0 || frame_cnt !== 16'd1) begin
      failures++;
      $display("FAIL vsc_commit x1=%0d y1=%0d pend=%0b frame=%0d required 100 200 0 1", x1, y1,
               pending, frame_cnt);
    end
    vsync = 1'b1; @(negedge clk);
  endtask

  task automatic test_clamp();
    drive(1'b1, 1'b0, B + 32'h04, 32'h000000F7);
    sb_q.push_back(32'h00000097);
    drive(1'b0, 1'b1, B + 32'h04, '0);
    exp_v = sb_q.pop_front();
    checks++;
    if (rdata !== exp_v) begin
      failures++; $display("FAIL clamp_p1_read rdata=%h required %h", rdata, exp_v);
    end
    drive(1'b1, 1'b0, B + 32'h10, 32'h02BC0123);
    sb_q.push_back(32'h01F40123);
    drive(1'b0, 1'b1, B + 32'h10, '0);
    exp_v = sb_q.pop_front();
    checks++;
    if (rdata !== exp_v) begin
      failures++; $display("FAIL clamp_y_read rdata=%h required %h", rdata, exp_v);
    end
    checks++;
    if (p1health !== 4'd0 || pending !== 1'b1) begin
      failures++; $display("FAIL clamp_precommit p1health=%0d pend=%0b required 0 1", p1health, pending);
    end
    drive(1'b1, 1'b0, B + 32'h14, 32'h3);
    checks++;
    if (p1health !== 4'd9 || p1Left !== 1'b1 || p1State !== 2'd3 || y2 !== 11'd500 ||
        x2 !== 11'h123 || pending !== 1'b0) begin
      failures++;
      $display("FAIL clamp_commit h=%0d l=%0b s=%0d y2=%0d x2=%h pend=%0b required 9 1 3 500 123 0",
               p1health, p1Left, p1State, y2, x2, pending);
    end
    idle(); @(negedge clk);
  endtask

  task automatic test_write_on_vsync();
    vsync = 1'b0;
    drive(1'b1, 1'b0, B + 32'h00, 32'h5);
    checks++;
    if (ack !== 1'b1 || gameState !== 3'd0 || pending !== 1'b1 || frame_cnt !== 16'd2) begin
      failures++;
      $display("FAIL wov_edge ack=%0b game=%0d pend=%0b frame=%0d required 1 0 1 2", ack, gameState,
               pending, frame_cnt);
    end
    idle(); vsync = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (gameState !== 3'd0) begin
      failures++; $display("FAIL wov_hold game=%0d required 0", gameState);
    end
    vsync = 1'b0; @(negedge clk);
    checks++;
    if (gameState !== 3'd5 || pending !== 1'b0 || frame_cnt !== 16'd3) begin
      failures++;
      $display("FAIL wov_next game=%0d pend=%0b frame=%0d required 5 0 3", gameState, pending, frame_cnt);
    end
    vsync = 1'b1; @(negedge clk);
  endtask

  task automatic test_immediate();
    drive(1'b1, 1'b0, B + 32'h14, 32'h0);
    sb_q.push_back(32'h0);
    drive(1'b0, 1'b1, B + 32'h14, '0);
    exp_v = sb_q.pop_front();
    checks++;
    if (rdata !== exp_v) begin
      failures++; $display("FAIL imm_mode_read rdata=%h required %h", rdata, exp_v);
    end
    drive(1'b1, 1'b0, B + 32'h08, 32'h00000032);
    checks++;
    if (p2health !== 4'd3 || p2State !== 2'd2 || p2Left !== 1'b0 || pending !== 1'b0) begin
      failures++;
      $display("FAIL imm_write h=%0d s=%0d l=%0b pend=%0b required 3 2 0 0", p2health, p2State,
               p2Left, pending);
    end
    idle(); vsync = 1'b0; @(negedge clk);
    checks++;
    if (frame_cnt !== 16'd4 || gameState !== 3'd5) begin
      failures++; $display("FAIL imm_vsync frame=%0d game=%0d required 4 5", frame_cnt, gameState);
    end
    vsync = 1'b1;
    drive(1'b1, 1'b0, B + 32'h14, 32'h3);
    checks++;
    if (ack !== 1'b1) begin
      failures++; $display("FAIL imm_force_ack ack=%0b required 1", ack);
    end
    sb_q.push_back(32'h1);
    drive(1'b0, 1'b1, B + 32'h14, '0);
    exp_v = sb_q.pop_front();
    checks++;
    if (rdata !== exp_v) begin
      failures++; $display("FAIL imm_ctrl_read rdata=%h required %h", rdata, exp_v);
    end
    idle(); @(negedge clk);
  endtask

  task automatic test_window();
    drive(1'b1, 1'b0, 32'hFE000000, 32'h7);
    checks++;
    if (ack !== 1'b0) begin
      failures++; $display("FAIL win_out_ack ack=%0b required 0", ack);
    end
    sb_q.push_back(32'h5);
    drive(1'b0, 1'b1, B + 32'h00, '0);
    exp_v = sb_q.pop_front();
    checks++;
    if (rdata !== exp_v) begin
      failures++; $display("FAIL win_out_noeffect rdata=%h required %h", rdata, exp_v);
    end
    drive(1'b0, 1'b1, 32'hFF000040, '0);
    checks++;
    if (ack !== 1'b1 || rdata !== 32'h0) begin
      failures++; $display("FAIL win_unmapped ack=%0b rdata=%h required 1 0", ack, rdata);
    end
    drive(1'b1, 1'b1, B + 32'h00, 32'h2);
    checks++;
    if (ack !== 1'b1 || rdata !== 32'h0 || pending !== 1'b1 || gameState !== 3'd5) begin
      failures++;
      $display("FAIL win_wr_rd ack=%0b rdata=%h pend=%0b game=%0d required 1 0 1 5", ack, rdata,
               pending, gameState);
    end
    idle(); @(negedge clk);
    checks++;
    if (ack !== 1'b0) begin
      failures++; $display("FAIL win_single_ack ack=%0b required 0", ack);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_list[5] = '{B + 32'h00, B + 32'h0C, B + 32'h10, B + 32'h18, B + 32'h14};
    logic [31:0] e_list[5] = '{32'h2, 32'h00C80064, 32'h01F40123, 32'h4, 32'h101};
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back(e_list[i]);
      drive(1'b0, 1'b1, a_list[i], '0);
      exp_v = sb_q.pop_front();
      checks++;
      if (ack !== 1'b1 || rdata !== exp_v) begin
        failures++; $display("FAIL b2b_read%0d ack=%0b rdata=%h required %h", i, ack, rdata, exp_v);
      end
    end
    idle(); @(negedge clk);
    checks++;
    if (ack !== 1'b0 || sb_q.size() != 0) begin
      failures++; $display("FAIL b2b_drain ack=%0b queue=%0d required 0 0", ack, sb_q.size());
    end
  endtask

  task automatic test_reset_mid();
    wr_en = 1'b1; addr = B + 32'h00; wdata = 32'h1;
    #10 rst = 1'b0;
    #20 idle();
    #10 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ack !== 1'b0 || gameState !== 3'd0 || pending !== 1'b0 || frame_cnt !== 16'd0) begin
      failures++;
      $display("FAIL rstmid ack=%0b game=%0d pend=%0b frame=%0d required 0 0 0 0", ack, gameState,
               pending, frame_cnt);
    end
    sb_q.push_back(32'h0);
    drive(1'b0, 1'b1, B + 32'h00, '0);
    exp_v = sb_q.pop_front();
    checks++;
    if (rdata !== exp_v) begin
      failures++; $display("FAIL rstmid_shadow rdata=%h required %h", rdata, exp_v);
    end
    idle(); @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_vsync_commit();
    test_clamp();
    test_write_on_vsync();
    test_immediate();
    test_window();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
